toggle_rx: RTL and testbench

TOGGLE_RX -- requirements
Module: toggle_rx

---
 rtl/toggle_rx.sv | 110 +++++++++++
 tb/tb_toggle_rx.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/toggle_rx.sv
// Receiver for a toggle-encoded event line: synchronizes TIN, strobes PULSE on
// each level change and keeps a saturating count of unacknowledged events.
module toggle_rx #(
    parameter int CW = 8
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          TIN,
    input  logic          ACK,
    input  logic          CLR,
    output logic          PULSE,
    output logic          VALID,
    output logic [CW-1:0] CNT,
    output logic          OVF
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PEND = 2'd1;
    localparam logic [1:0] ST_SAT  = 2'd2;

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic          s1_q, s2_q, s3_q;
    logic          edge_det;
    logic [1:0]    state_d, state_q;
    logic [CW-1:0] cnt_d, cnt_q;
    logic          valid_d, valid_q;
    logic          pulse_d, pulse_q;
    logic          ovf_d, ovf_q;
    logic          lost;

    function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] c);
        return (c == CNT_MAX) ? c : c + CW'(1);
    endfunction

    function automatic logic [CW-1:0] cnt_dec(input logic [CW-1:0] c);
        return (c == '0) ? c : c - CW'(1);
    endfunction

    // The synchronizer chain ignores reset so it mirrors TIN and no edge
    // is fabricated when reset is released.
    always_ff @(posedge CLK) begin
        s1_q <= TIN;
        s2_q <= s1_q;
        s3_q <= s2_q;
    end

    assign edge_det = s2_q ^ s3_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lost    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (edge_det) begin
                    cnt_d   = CW'(1);
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (edge_det && !ACK) begin
                    cnt_d = cnt_inc(cnt_q);
                    if (cnt_d == CNT_MAX) state_d = ST_SAT;
                end else if (ACK && !edge_det) begin
                    cnt_d = cnt_dec(cnt_q);
                    if (cnt_d == '0) state_d = ST_IDLE;
                end
            end
            ST_SAT: begin
                if (edge_det && !ACK) begin
                    lost = 1'b1;
                end else if (ACK && !edge_det) begin
                    cnt_d   = cnt_dec(cnt_q);
                    state_d = ST_PEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        // A lost event wins over a same-cycle clear.
        ovf_d   = lost | (ovf_q & ~CLR);
        valid_d = (cnt_d != '0);
        pulse_d = edge_det;
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            pulse_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            pulse_q <= pulse_d;
            ovf_q   <= ovf_d;
        end
    end

    assign PULSE = pulse_q;
    assign VALID = valid_q;
    assign CNT   = cnt_q;
    assign OVF   = ovf_q;

endmodule

// File: tb/tb_toggle_rx.sv
// Scoreboard bench for toggle_rx: a CW=8 instance for latency/count tests and
// a CW=2 instance for saturation, overflow and mid-operation reset.
module tb_toggle_rx;

    logic       clk = 1'b0;
    logic [1:0] rstn, tin, ack, clr;
    logic       pulse0, valid0, ovf0;
    logic       pulse1, valid1, ovf1;
    logic [7:0] cnt0;
    logic [1:0] cnt1;

    int n_checks = 0;
    int n_fail   = 0;
    int q0[$];
    int q1[$];

    always #5 clk = ~clk;

    toggle_rx #(.CW(8)) dut0 (
        .CLK(clk), .RSTn(rstn[0]), .TIN(tin[0]), .ACK(ack[0]), .CLR(clr[0]),
        .PULSE(pulse0), .VALID(valid0), .CNT(cnt0), .OVF(ovf0)
    );

    toggle_rx #(.CW(2)) dut1 (
        .CLK(clk), .RSTn(rstn[1]), .TIN(tin[1]), .ACK(ack[1]), .CLR(clr[1]),
        .PULSE(pulse1), .VALID(valid1), .CNT(cnt1), .OVF(ovf1)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Toggle TIN and record the CNT expected once the resulting PULSE appears.
    task automatic flip(input int d, input int exp_cnt);
        tin[d] = ~tin[d];
        if (d == 0) q0.push_back(exp_cnt);
        else        q1.push_back(exp_cnt);
    endtask

    always @(negedge clk) begin
        if (pulse0) begin
            if (q0.size() == 0) chk("spurious_pulse0", 1, 0);
            else                chk("pulse_cnt0", int'(cnt0), q0.pop_front());
        end
        if (pulse1) begin
            if (q1.size() == 0) chk("spurious_pulse1", 1, 0);
            else                chk("pulse_cnt1", int'(cnt1), q1.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int retire_exp[7];
        retire_exp = '{4, 3, 2, 1, 0, 0, 0};
        rstn = 2'b00; tin = 2'b11; ack = 2'b00; clr = 2'b00;

        // Reset with TIN=1 for 4 cycles
        repeat (4) tick();
        chk("rst_cnt0", int'(cnt0), 0);
        chk("rst_valid0", int'(valid0), 0);
        chk("rst_ovf0", int'(ovf0), 0);
        chk("rst_pulse0", int'(pulse0), 0);
        chk("rst_cnt1", int'(cnt1), 0);
        chk("rst_ovf1", int'(ovf1), 0);
        rstn = 2'b11;
        repeat (5) tick();

        // Single toggle: change captured at edge 10, pulse after edge 12
        flip(0, 1);
        tick(); chk("lat_e10", int'(pulse0), 0);
        tick(); chk("lat_e11", int'(pulse0), 0);
        tick(); chk("lat_e12", int'(pulse0), 1);
        chk("single_cnt", int'(cnt0), 1);
        chk("single_valid", int'(valid0), 1);
        chk("single_ovf", int'(ovf0), 0);
        tick(); chk("lat_e13", int'(pulse0), 0);

        ack[0] = 1'b1; tick(); ack[0] = 1'b0;
        chk("ack_cnt", int'(cnt0), 0);
        chk("ack_valid", int'(valid0), 0);

        // Accumulate five events, then retire with seven ACK cycles
        for (int i = 1; i <= 5; i++) begin
            flip(0, i);
            repeat (4) tick();
        end
        chk("accum_cnt", int'(cnt0), 5);
        ack[0] = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("retire_cnt", int'(cnt0), retire_exp[i]);
            chk("retire_valid", int'(valid0), int'(retire_exp[i] != 0));
        end
        ack[0] = 1'b0;

        // Simultaneous ACK and EDGE at CNT=3
        for (int i = 1; i <= 3; i++) begin
            flip(0, i);
            repeat (4) tick();
        end
        flip(0, 3);
        tick(); tick();
        ack[0] = 1'b1;
        tick();
        ack[0] = 1'b0;
        chk("simul_pulse", int'(pulse0), 1);
        chk("simul_cnt", int'(cnt0), 3);
        tick();
        chk("simul_hold", int'(cnt0), 3);

        // Saturation on CW=2
        flip(1, 1); repeat (4) tick();
        flip(1, 2); repeat (4) tick();
        flip(1, 3); repeat (4) tick();
        chk("sat_no_ovf", int'(ovf1), 0);
        flip(1, 3); repeat (4) tick();
        chk("sat_cnt", int'(cnt1), 3);
        chk("sat_ovf", int'(ovf1), 1);
        flip(1, 3);
        tick(); tick();
        clr[1] = 1'b1;
        tick();
        clr[1] = 1'b0;
        chk("clr_vs_lost", int'(ovf1), 1);
        tick();
        clr[1] = 1'b1; tick(); clr[1] = 1'b0;
        chk("clr_ovf", int'(ovf1), 0);
        chk("clr_cnt", int'(cnt1), 3);

        // SAT with EDGE and ACK together: counted, nothing lost
        flip(1, 3);
        tick(); tick();
        ack[1] = 1'b1;
        tick();
        ack[1] = 1'b0;
        chk("sat_simul_cnt", int'(cnt1), 3);
        chk("sat_simul_ovf", int'(ovf1), 0);
        tick();

        // Reach CNT=2 with OVF=1
        flip(1, 3); repeat (4) tick();
        ack[1] = 1'b1; tick(); ack[1] = 1'b0;
        chk("pre_rst_cnt", int'(cnt1), 2);
        chk("pre_rst_ovf", int'(ovf1), 1);

        // Mid-operation reset with ACK high and a toggle in flight (no pulse expected)
        ack[1] = 1'b1;
        tin[1] = ~tin[1];
        tick();
        rstn[1] = 1'b0;
        repeat (3) tick();
        chk("mid_rst_cnt", int'(cnt1), 0);
        chk("mid_rst_ovf", int'(ovf1), 0);
        chk("mid_rst_valid", int'(valid1), 0);
        rstn[1] = 1'b1;
        ack[1] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post_rst_pulse", int'(pulse1), 0);
        end
        chk("post_rst_cnt", int'(cnt1), 0);

        tick();
        chk("sb_drain0", q0.size(), 0);
        chk("sb_drain1", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
